// File: rtl/sp_packet_buffer.sv
// rtl/sp_packet_buffer.sv - commit/rollback packet buffer between the service-protocol unpacker and the command dispatcher
// Words land tentatively at wrTmp; a descriptor is published only when the packet ends with a good CRC.
module sp_packet_buffer #(
  parameter int ADDR_LOG2 = 6,
  parameter int DESC_LOG2 = 2,
  parameter int CMD_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_request,
  output logic             in_done,
  input  logic             pkt_start,
  input  logic             pkt_end,
  input  logic             pkt_err,
  input  logic [7:0]       in_addr,
  input  logic [CMD_W-1:0] in_cmd,
  output logic             out_valid,
  output logic [7:0]       out_addr,
  output logic [CMD_W-1:0] out_cmd,
  output logic [8:0]       out_size,
  output logic [15:0]      out_data,
  input  logic             out_rd,
  input  logic             out_ack,
  output logic             overflow
);
  localparam int PW     = ADDR_LOG2 + 1;
  localparam int DEPTH  = 1 << ADDR_LOG2;
  localparam int DW     = DESC_LOG2 + 1;
  localparam int DDEPTH = 1 << DESC_LOG2;
  localparam logic [PW-1:0] FULL_GAP  = PW'(DEPTH);
  localparam logic [DW-1:0] DFULL_GAP = DW'(DDEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DROP} wrState_t;

  wrState_t state, stateNext;

  logic [15:0]      mem [DEPTH];
  logic [7:0]       descAddr [DDEPTH];
  logic [CMD_W-1:0] descCmd  [DDEPTH];
  logic [8:0]       descSize [DDEPTH];
  logic [PW-1:0]    descBase [DDEPTH];

  logic [PW-1:0]    wrTmp, wrCmt, rdFree, rdPtr;
  logic [PW-1:0]    wrTmpNext, wrCmtNext, wrBase, wrAddr, headEnd;
  logic [8:0]       cnt, cntNext, cntBase, pktSize;
  logic [DW-1:0]    dWr, dRd;
  logic [DESC_LOG2-1:0] headIdx;
  logic [7:0]       hdrAddr, hdrAddrNow;
  logic [CMD_W-1:0] hdrCmd, hdrCmdNow;
  logic             hdrCapture, startNew, memWe, push, pop, ovfNext, dropNow, descFull;

  // The header is sampled on the same cycle it is used, so a zero-length packet gets its own address.
  assign hdrCapture = pkt_start | in_request | pkt_end;
  assign hdrAddrNow = hdrCapture ? in_addr : hdrAddr;
  assign hdrCmdNow  = hdrCapture ? in_cmd  : hdrCmd;

  assign out_valid = (dWr != dRd);
  assign headIdx   = dRd[DESC_LOG2-1:0];
  assign headEnd   = descBase[headIdx] + PW'(descSize[headIdx]);
  assign pop       = out_ack & out_valid;
  assign descFull  = ((dWr - dRd) == DFULL_GAP);

  assign out_addr = out_valid ? descAddr[headIdx] : '0;
  assign out_cmd  = out_valid ? descCmd[headIdx]  : '0;
  assign out_size = out_valid ? descSize[headIdx] : '0;
  assign out_data = out_valid ? mem[rdPtr[ADDR_LOG2-1:0]] : '0;

  always_comb begin
    stateNext = state;
    wrTmpNext = wrTmp;
    wrCmtNext = wrCmt;
    cntNext   = cnt;
    pktSize   = cnt;
    wrAddr    = wrTmp;
    memWe     = 1'b0;
    push      = 1'b0;
    ovfNext   = 1'b0;
    dropNow   = 1'b0;
    // A word with pkt_start while filling abandons the open packet and restarts at the commit point.
    startNew  = (state == IDLE) || pkt_start;
    wrBase    = startNew ? wrCmt : wrTmp;
    cntBase   = startNew ? 9'd0 : cnt;
    if (state == DROP) begin
      if (pkt_end || pkt_err) stateNext = IDLE;
    end else begin
      if (in_request) begin
        if (((wrBase - rdFree) != FULL_GAP) && (cntBase != 9'd256)) begin
          memWe     = 1'b1;
          wrAddr    = wrBase;
          wrTmpNext = wrBase + PW'(1);
          cntNext   = cntBase + 9'd1;
          stateNext = FILL;
        end else begin
          wrTmpNext = wrCmt;
          cntNext   = 9'd0;
          ovfNext   = 1'b1;
          dropNow   = 1'b1;
          stateNext = DROP;
        end
      end
      pktSize = cntNext;
      if (pkt_err) begin
        wrTmpNext = wrCmt;
        cntNext   = 9'd0;
        stateNext = IDLE;
      end else if (pkt_end) begin
        stateNext = IDLE;
        cntNext   = 9'd0;
        if (!dropNow) begin
          // A same-cycle pop makes room, so a full FIFO still takes this push.
          if (!descFull || pop) begin
            push      = 1'b1;
            wrCmtNext = wrTmpNext;
          end else begin
            wrTmpNext = wrCmt;
            ovfNext   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wrTmp    <= '0;
      wrCmt    <= '0;
      rdFree   <= '0;
      rdPtr    <= '0;
      cnt      <= '0;
      dWr      <= '0;
      dRd      <= '0;
      hdrAddr  <= '0;
      hdrCmd   <= '0;
      in_done  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      wrTmp    <= wrTmpNext;
      wrCmt    <= wrCmtNext;
      cnt      <= cntNext;
      hdrAddr  <= hdrAddrNow;
      hdrCmd   <= hdrCmdNow;
      in_done  <= in_request;
      overflow <= ovfNext;
      if (push) dWr <= dWr + DW'(1);
      if (pop) begin
        dRd    <= dRd + DW'(1);
        rdFree <= headEnd;
        rdPtr  <= headEnd;
      end else if (out_rd && out_valid && (rdPtr != headEnd)) begin
        rdPtr <= rdPtr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[wrAddr[ADDR_LOG2-1:0]] <= in_data;
    if (push) begin
      descAddr[dWr[DESC_LOG2-1:0]] <= hdrAddrNow;
      descCmd[dWr[DESC_LOG2-1:0]]  <= hdrCmdNow;
      descSize[dWr[DESC_LOG2-1:0]] <= pktSize;
      descBase[dWr[DESC_LOG2-1:0]] <= wrCmt;
    end
  end
endmodule

// File: tb/tb_sp_packet_buffer.sv
// tb/tb_sp_packet_buffer.sv - scoreboard bench for sp_packet_buffer (8-word memory, 4 descriptors)
module tb_sp_packet_buffer;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] in_data;
  logic in_request, in_done, pkt_start, pkt_end, pkt_err;
  logic [7:0] in_addr;
  logic [3:0] in_cmd;
  logic out_valid;
  logic [7:0] out_addr;
  logic [3:0] out_cmd;
  logic [8:0] out_size;
  logic [15:0] out_data;
  logic out_rd, out_ack, overflow;
  logic rdStim, rdCons, ackStim, ackCons;

  assign out_rd  = rdStim | rdCons;
  assign out_ack = ackStim | ackCons;

  sp_packet_buffer #(.ADDR_LOG2(3), .DESC_LOG2(2), .CMD_W(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_request(in_request), .in_done(in_done),
    .pkt_start(pkt_start), .pkt_end(pkt_end), .pkt_err(pkt_err), .in_addr(in_addr), .in_cmd(in_cmd),
    .out_valid(out_valid), .out_addr(out_addr), .out_cmd(out_cmd), .out_size(out_size),
    .out_data(out_data), .out_rd(out_rd), .out_ack(out_ack), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] cmd;
    int         size;
  } desc_t;

  desc_t       expQ[$];
  logic [15:0] wordQ[$];
  int nCmp = 0;
  int nBad = 0;
  int ovfCnt = 0;
  int ovfAt = -1;
  int curWord = -1;
  bit consume = 0;
  bit busy = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // endKind: 0 = pkt_end, 1 = pkt_err, 2 = none; merge puts the end pulse on the last word.
  task automatic sendPkt(input logic [7:0] a, input logic [3:0] c, input int n, input logic [15:0] w0,
                         input int endKind, input bit expCommit, input bit merge, input bit ackEnd);
    if (ackEnd && expQ.size() > 0) begin
      desc_t h;
      h = expQ.pop_front();
      for (int i = 0; i < h.size; i++) void'(wordQ.pop_front());
    end
    if (expCommit) begin
      expQ.push_back('{addr: a, cmd: c, size: n});
      for (int i = 0; i < n; i++) wordQ.push_back(w0 + 16'(i));
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_data    = w0 + 16'(i);
      in_request = 1'b1;
      pkt_start  = (i == 0);
      in_addr    = a;
      in_cmd     = c;
      curWord    = i;
      pkt_end    = merge && (i == n - 1) && (endKind == 0);
      pkt_err    = merge && (i == n - 1) && (endKind == 1);
      ackStim    = merge && (i == n - 1) && ackEnd;
    end
    if (!(merge && n > 0)) begin
      @(posedge clk); #1;
      in_request = 1'b0;
      pkt_start  = 1'b0;
      curWord    = -1;
      in_addr    = a;
      in_cmd     = c;
      pkt_end    = (endKind == 0);
      pkt_err    = (endKind == 1);
      ackStim    = ackEnd;
    end
    @(posedge clk); #1;
    in_request = 1'b0;
    pkt_start  = 1'b0;
    pkt_end    = 1'b0;
    pkt_err    = 1'b0;
    ackStim    = 1'b0;
    curWord    = -1;
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((expQ.size() != 0 || busy || out_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_within_budget", 32'(t < 400), 32'd1);
  endtask

  // Handshake and overflow monitor.
  initial begin
    bit lastReq = 1'b0;
    int prevWord = -1;
    forever begin
      @(negedge clk);
      if (lastReq || in_done) chk("in_done_lag", 32'(in_done), 32'(lastReq));
      lastReq = in_request;
      if (overflow) begin
        ovfCnt++;
        ovfAt = prevWord;
      end
      prevWord = curWord;
    end
  end

  // Consumer: pops the expected descriptor, reads every word, probes the read clamp, then acks.
  initial begin
    desc_t d;
    logic [15:0] held;
    rdCons = 1'b0;
    ackCons = 1'b0;
    forever begin
      @(negedge clk);
      if (consume && out_valid) begin
        busy = 1;
        if (expQ.size() == 0) begin
          nCmp++;
          nBad++;
          $display("FAIL unexpected_descriptor: got addr %0h size %0d, expected none", out_addr, out_size);
          ackCons = 1'b1;
          @(negedge clk);
          ackCons = 1'b0;
        end else begin
          d = expQ.pop_front();
          chk("out_addr", 32'(out_addr), 32'(d.addr));
          chk("out_cmd", 32'(out_cmd), 32'(d.cmd));
          chk("out_size", 32'(out_size), 32'(d.size));
          for (int i = 0; i < d.size; i++) begin
            chk("out_data", 32'(out_data), 32'(wordQ.pop_front()));
            rdCons = 1'b1;
            @(negedge clk);
            rdCons = 1'b0;
          end
          held = out_data;
          rdCons = 1'b1;
          @(negedge clk);
          rdCons = 1'b0;
          chk("rd_clamp", 32'(out_data), 32'(held));
          ackCons = 1'b1;
          @(negedge clk);
          ackCons = 1'b0;
        end
        busy = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    in_data = '0; in_request = 0; pkt_start = 0; pkt_end = 0; pkt_err = 0;
    in_addr = '0; in_cmd = '0; rdStim = 0; ackStim = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_done", 32'(in_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_cmd", 32'(out_cmd), 32'd0);
    chk("rst_out_size", 32'(out_size), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // Basic 4-word packet, descriptor visible the cycle after pkt_end.
    sendPkt(8'h12, 4'h3, 4, 16'hA001, 0, 1, 0, 0);
    @(negedge clk);
    chk("t1_valid_next_cycle", 32'(out_valid), 32'd1);
    chk("t1_size", 32'(out_size), 32'd4);
    chk("t1_first_word", 32'(out_data), 32'hA001);
    consume = 1;
    waitDrain();
    chk("t1_released", 32'(out_valid), 32'd0);

    // CRC error discards, following good packet is the only descriptor; word+end merged.
    sendPkt(8'h20, 4'h1, 3, 16'hE000, 1, 0, 0, 0);
    sendPkt(8'h21, 4'h2, 2, 16'hE100, 0, 1, 0, 0);
    waitDrain();
    sendPkt(8'h22, 4'h5, 3, 16'hE200, 0, 1, 1, 0);
    waitDrain();

    // Zero-length packet: size 0, out_rd does not move past the next packet's first word.
    consume = 0;
    sendPkt(8'h05, 4'h7, 0, 16'h0000, 0, 1, 0, 0);
    sendPkt(8'h06, 4'h1, 2, 16'hD000, 0, 1, 0, 0);
    @(negedge clk);
    chk("z_size", 32'(out_size), 32'd0);
    chk("z_addr", 32'(out_addr), 32'h05);
    chk("z_data_before_rd", 32'(out_data), 32'hD000);
    rdStim = 1'b1;
    @(negedge clk);
    rdStim = 1'b0;
    chk("z_data_after_rd", 32'(out_data), 32'hD000);
    consume = 1;
    waitDrain();

    // Data-space overflow on the 3rd word of a 4-word packet behind an unacked 6-word packet.
    consume = 0;
    base = ovfCnt;
    ovfAt = -1;
    sendPkt(8'h30, 4'h1, 6, 16'hB000, 0, 1, 0, 0);
    sendPkt(8'h31, 4'h2, 4, 16'hC000, 0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_pulses", 32'(ovfCnt - base), 32'd1);
    chk("ovf_word_index", 32'(ovfAt), 32'd2);
    chk("ovf_head_addr", 32'(out_addr), 32'h30);
    chk("ovf_head_size", 32'(out_size), 32'd6);
    consume = 1;
    waitDrain();
    base = ovfCnt;
    sendPkt(8'h31, 4'h2, 4, 16'hC000, 0, 1, 0, 0);
    waitDrain();
    chk("ovf_resend_clean", 32'(ovfCnt - base), 32'd0);

    // Descriptor FIFO full drops the 5th; a same-cycle ack lets it in.
    consume = 0;
    base = ovfCnt;
    for (int k = 0; k < 4; k++)
      sendPkt(8'h40 + 8'(k), 4'(k), 1, 16'h5000 + 16'(k), 0, 1, 0, 0);
    sendPkt(8'h44, 4'h4, 1, 16'h5004, 0, 0, 0, 0);
    @(negedge clk);
    chk("fifo_full_ovf", 32'(ovfCnt - base), 32'd1);
    chk("fifo_full_head", 32'(out_addr), 32'h40);
    base = ovfCnt;
    sendPkt(8'h45, 4'h5, 1, 16'h5005, 0, 1, 0, 1);
    @(negedge clk);
    chk("fifo_ack_push_ovf", 32'(ovfCnt - base), 32'd0);
    chk("fifo_ack_head", 32'(out_addr), 32'h41);
    consume = 1;
    waitDrain();

    // Pointer wrap: 20 packets of 5 words through an 8-word memory.
    for (int p = 0; p < 20; p++) begin
      sendPkt(8'h60 + 8'(p), p[3:0], 5, 16'h0010 + 16'(p * 256), 0, 1, 0, 0);
      waitDrain();
    end
    chk("final_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/sp_packet_buffer.md
# sp_packet_buffer

Commit/rollback packet buffer directly downstream of the service-protocol unpacker. It stores the data words of each incoming packet in a circular word memory. It publishes a descriptor (address, command, size, base) only when the packet ends with a good CRC (`pkt_end`), and discards the words on `pkt_err`, overflow or an aborted packet. The command dispatcher pops complete, CRC-checked packets from the output side.

## Interface
- `ADDR_LOG2`, 6: data memory holds `2**ADDR_LOG2` 16-bit words.
- `DESC_LOG2`, 2: descriptor FIFO holds `2**DESC_LOG2` packets.
- `CMD_W`, 4: width of the command code.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `in_data`  in  16  data word; valid when `in_request`=1.
- `in_request`  in  1  one-cycle pulse per data word.
- `in_done`  out  1  one-cycle acknowledge, issued the cycle after each `in_request`.
- `pkt_start`  in  1  pulse that coincides with the first data word of a packet.
- `pkt_end`  in  1  pulse: packet complete, CRC good.
- `pkt_err`  in  1  pulse: packet failed CRC.
- `in_addr`  in  8  module address; valid while `pkt_start`, `in_request` or `pkt_end` is high.
- `in_cmd`  in  CMD_W  command code; same validity as `in_addr`.
- `out_valid`  out  1  descriptor FIFO is not empty.
- `out_addr`  out  8  address from the head descriptor.
- `out_cmd`  out  CMD_W  command from the head descriptor.
- `out_size`  out  9  word count from the head descriptor, range 0..256.
- `out_data`  out  16  memory word at the read pointer.
- `out_rd`  in  1  advance the read pointer by one word.
- `out_ack`  in  1  release the head descriptor and its words.
- `overflow`  out  1  one-cycle pulse when a packet is dropped for lack of space.

## Operation
- Pointers are ADDR_LOG2+1 bits wide and wrap modulo `2**(ADDR_LOG2+1)`:
  - `wr_tmp`: tentative write pointer.
  - `wr_cmt`: committed write pointer.
  - `rd_free`: base of the oldest unreleased packet.
  - `rd_ptr`: consumer read pointer.
- Buffer full: `wr_tmp - rd_free == 2**ADDR_LOG2`.
- `cnt`: 9-bit count of words in the current packet.
- Header capture: `hdr_addr` and `hdr_cmd` are loaded from `in_addr`/`in_cmd` on any cycle where `pkt_start`, `in_request` or `pkt_end` is high.
- Write FSM, states IDLE, FILL, DROP:
  - IDLE:
    - `in_request` → write `in_data` at `wr_tmp`, `wr_tmp`+1, `cnt`=1, go to FILL.
    - `pkt_end` with no data (zero-length packet) → commit with size 0.
  - FILL:
    - `in_request` with buffer not full and `cnt`<256 → write the word, `cnt`+1.
    - Otherwise `in_request` → rollback (`wr_tmp`←`wr_cmt`), pulse `overflow`, go to DROP.
    - `pkt_start` together with `in_request` → abort the open packet: rollback, then write the word as word 0 of a new packet, `cnt`=1.
  - DROP: ignore data; on `pkt_end` or `pkt_err` go to IDLE, with no commit.
- Commit (`pkt_end` in IDLE/FILL):
  - Descriptor FIFO not full → push {`hdr_addr`, `hdr_cmd`, `cnt`, base=`wr_cmt`}, set `wr_cmt`←`wr_tmp`, go to IDLE.
  - Descriptor FIFO full → rollback, pulse `overflow`, go to IDLE.
- `pkt_err` in IDLE/FILL: rollback, go to IDLE.
- Read side:
  - `out_data` = mem[`rd_ptr`], combinational read of the registered pointer.
  - `out_rd` increments `rd_ptr`, but not past base+size of the head descriptor.
  - `out_ack` pops the head descriptor and sets `rd_free` and `rd_ptr` to base+size of the popped descriptor, skipping any unread words.
  - `out_rd`/`out_ack` while `out_valid`=0 are ignored.
- Reset: all pointers 0, FSM IDLE, FIFO empty. `in_done`=0, `out_valid`=0, `overflow`=0; `out_addr`, `out_cmd`, `out_size`, `out_data`=0.

## Timing
- `in_done` follows every `in_request` by exactly 1 cycle, including dropped words.
- A descriptor is visible on `out_valid` the cycle after `pkt_end`. Its data is readable in that same cycle.
- `in_request` and `pkt_end` in the same cycle: the word is written first and is included in the committed packet.
- `in_request` and `pkt_err` in the same cycle: the word is discarded.
- Commit and `out_ack` in the same cycle: the FIFO count is unchanged, and a full FIFO accepts the push.
- Space freed by `out_ack` counts toward the full check from the next cycle.
- `rst` during FILL: the open packet and all stored packets are lost.

## Test plan
- Packet addr 0x12, cmd 3, words 0xA001..0xA004 then `pkt_end` → `out_valid`=1 next cycle, `out_size`=4, four `out_rd` reads give 0xA001..0xA004, `out_ack` → `out_valid`=0.
- Three words then `pkt_err`, then a 2-word good packet → only a single descriptor, size 2, and its data matches the 2-word packet.
- Zero-length packet (`pkt_end` only, addr 0x05) → descriptor with `out_size`=0; `out_rd` has no effect.
- ADDR_LOG2=3 (8 words): store a 6-word packet unacked, then send a 4-word packet → `overflow` pulse on the 3rd word of the second packet, no second descriptor, first packet intact. After `out_ack` of the first, resending the 4-word packet succeeds.
- Fill 4 descriptors, then a 5th `pkt_end` → `overflow` pulse, 5th packet dropped. Repeat with `out_ack` in the same cycle as that `pkt_end` → the 5th packet is committed.
- Pointer wrap: stream 20 packets of 5 words each with ack after each → all data correct across the wrap; each `in_done` lags its `in_request` by 1 cycle.
